// File: rtl/reg_native_pkg.sv
// Shared types and helpers for the reg_native memory responder slice.
package reg_native_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 64;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned WAIT_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned word_lsb(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/reg_native_sram.sv
// Single-port word array with a registered read port that can also be cleared.
module reg_native_sram #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] widx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Storage has no reset so it maps onto plain flops or a macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Read register: loads on a read hit, returns to zero when cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[widx];
    end else if (clr) begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/reg_native_mem_responder.sv
// Responder end of reg_native_if: decodes a byte window onto a word memory and
// acknowledges one transaction at a time after a fixed number of wait states.
module reg_native_mem_responder
  import reg_native_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned           MEM_AW      = 6,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(64'h200),
  parameter int unsigned           WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  input  logic                  ack_rdy,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned           BPW       = bytes_per_word(DATA_WIDTH);
  localparam int unsigned           LSB       = word_lsb(DATA_WIDTH);
  localparam int unsigned           DEPTH     = 32'd1 << MEM_AW;
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(DEPTH * BPW);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                state;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  hit;
  logic [MEM_AW-1:0]     widx;
  logic                  accept;
  logic                  is_wr;
  logic                  is_rd;
  logic                  mem_we;
  logic                  mem_re;
  logic                  rd_clr;

  // Address decode; the lower-bound test also rejects offsets that wrapped.
  assign offset = addr - BASE_ADDR;
  assign hit    = (addr >= BASE_ADDR) && (offset < WIN_BYTES);
  assign widx   = MEM_AW'(offset >> LSB);

  assign accept = (state == IDLE) && req_vld && req_rdy;
  assign is_wr  = wr_en && !rd_en;
  assign is_rd  = rd_en && !wr_en;
  assign mem_we = accept && is_wr && hit;
  assign mem_re = accept && is_rd && hit;
  assign rd_clr = (state == ACK) && ack_vld && ack_rdy;

  // Handshake FSM with wait-state counter; all outputs are registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      req_rdy  <= 1'b0;
      ack_vld  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_rdy <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state   <= ACK;
              ack_vld <= 1'b1;
            end
          end else begin
            req_rdy <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state   <= ACK;
            ack_vld <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ACK: begin
          if (ack_rdy) begin
            state   <= IDLE;
            ack_vld <= 1'b0;
            req_rdy <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          req_rdy  <= 1'b0;
          ack_vld  <= 1'b0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // The array's read register is the rd_data output: zero unless a read hit.
  reg_native_sram #(
    .DW(DATA_WIDTH),
    .AW(MEM_AW)
  ) u_sram (
    .clk  (clk),
    .rstn (rstn),
    .we   (mem_we),
    .re   (mem_re),
    .clr  (rd_clr),
    .widx (widx),
    .wdata(wr_data),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_reg_native_mem_responder.sv
// Bench for reg_native_mem_responder: two instances (0 and 3 wait states),
// directed vector table, hand-written reset/idle sequences and random traffic.
module tb_reg_native_mem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_vld [2];
  logic        req_rdy [2];
  logic        wr_en   [2];
  logic        rd_en   [2];
  logic [63:0] addr    [2];
  logic [31:0] wr_data [2];
  logic        ack_vld [2];
  logic        ack_rdy [2];
  logic [31:0] rd_data [2];

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mdl [2][64];

  typedef struct {
    int          d;
    logic        w;
    logic        r;
    logic [63:0] a;
    logic [31:0] wd;
    int          hold;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  reg_native_mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rstn(rstn), .req_vld(req_vld[0]), .req_rdy(req_rdy[0]),
    .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]), .wr_data(wr_data[0]),
    .ack_vld(ack_vld[0]), .ack_rdy(ack_rdy[0]), .rd_data(rd_data[0])
  );

  reg_native_mem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rstn(rstn), .req_vld(req_vld[1]), .req_rdy(req_rdy[1]),
    .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]), .wr_data(wr_data[1]),
    .ack_vld(ack_vld[1]), .ack_rdy(ack_rdy[1]), .rd_data(rd_data[1])
  );

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: 256-byte window at 0x200, 4-byte words; misses and illegal ops return 0.
  function automatic logic [31:0] model_op(input int d, input logic w, input logic r,
                                           input logic [63:0] a, input logic [31:0] wd);
    logic hit;
    int   idx;
    hit = (a >= 64'h200) && (a < 64'h300);
    idx = hit ? int'((a - 64'h200) / 4) : 0;
    if (w == r) return 32'h0;
    if (w) begin
      if (hit) mdl[d][idx] = wd;
      return 32'h0;
    end
    return hit ? mdl[d][idx] : 32'h0;
  endfunction

  function automatic vec_t mk(input int d, input logic w, input logic r, input logic [63:0] a,
                              input logic [31:0] wd, input int hold, input logic [31:0] exp);
    vec_t v;
    v.d = d; v.w = w; v.r = r; v.a = a; v.wd = wd; v.hold = hold; v.exp = exp;
    return v;
  endfunction

  // One full transaction; hold<0 raises ack_rdy early, hold>0 back-pressures.
  task automatic txn(input int d, input logic w, input logic r, input logic [63:0] a,
                     input logic [31:0] wd, input int hold, input logic [31:0] exp);
    int n;
    n = 0;
    while (req_rdy[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("req_rdy_wait d%0d a=%0h", d, a), 64'(req_rdy[d]), 64'd1);
    req_vld[d] = 1'b1; wr_en[d] = w; rd_en[d] = r; addr[d] = a; wr_data[d] = wd;
    @(negedge clk);
    req_vld[d] = 1'b0;
    wr_en[d]   = 1'($urandom);
    rd_en[d]   = 1'($urandom);
    addr[d]    = {$urandom, $urandom};
    wr_data[d] = $urandom;
    if (hold < 0) ack_rdy[d] = 1'b1;
    n = 1;
    while (ack_vld[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ack_latency d%0d a=%0h", d, a), 64'(n), 64'(wc(d) + 1));
    chk($sformatf("ack_rd_data d%0d a=%0h", d, a), 64'(rd_data[d]), 64'(exp));
    chk($sformatf("req_rdy_in_ack d%0d", d), 64'(req_rdy[d]), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("bp_ack_vld d%0d", d), 64'(ack_vld[d]), 64'd1);
      chk($sformatf("bp_rd_data d%0d", d), 64'(rd_data[d]), 64'(exp));
      chk($sformatf("bp_req_rdy d%0d", d), 64'(req_rdy[d]), 64'd0);
    end
    ack_rdy[d] = 1'b1;
    @(negedge clk);
    ack_rdy[d] = 1'b0;
    chk($sformatf("post_ack_vld d%0d", d), 64'(ack_vld[d]), 64'd0);
    chk($sformatf("post_rd_data d%0d", d), 64'(rd_data[d]), 64'd0);
    chk($sformatf("post_req_rdy d%0d", d), 64'(req_rdy[d]), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] m;
    m = model_op(v.d, v.w, v.r, v.a, v.wd);
    txn(v.d, v.w, v.r, v.a, v.wd, v.hold, v.exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_vld[d] = 1'b0; wr_en[d] = 1'b0; rd_en[d] = 1'b0;
      addr[d] = '0; wr_data[d] = '0; ack_rdy[d] = 1'b0;
    end

    // Directed vectors: {dut, wr, rd, addr, wdata, hold, expected rd_data}
    tbl.push_back(mk(0, 1, 0, 64'h200, 32'hFFFFFFFF, 0,  32'h0));
    tbl.push_back(mk(0, 0, 1, 64'h200, 32'h0,        0,  32'hFFFFFFFF));
    tbl.push_back(mk(1, 1, 0, 64'h2FC, 32'hA5A5A5A5, 0,  32'h0));
    tbl.push_back(mk(1, 0, 1, 64'h2FC, 32'h0,        0,  32'hA5A5A5A5));
    tbl.push_back(mk(1, 0, 1, 64'h2FF, 32'h0,        -1, 32'hA5A5A5A5));
    tbl.push_back(mk(0, 1, 0, 64'h2FC, 32'hDEADBEEF, 0,  32'h0));
    tbl.push_back(mk(0, 1, 0, 64'h300, 32'h12345678, 0,  32'h0));
    tbl.push_back(mk(0, 1, 0, 64'h1FC, 32'h12345678, 0,  32'h0));
    tbl.push_back(mk(0, 0, 1, 64'h300, 32'h0,        0,  32'h0));
    tbl.push_back(mk(0, 0, 1, 64'h2FC, 32'h0,        0,  32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 1, 64'h200, 32'h0,        0,  32'hFFFFFFFF));
    tbl.push_back(mk(0, 1, 0, 64'h204, 32'hCAFEF00D, 0,  32'h0));
    tbl.push_back(mk(0, 0, 1, 64'h204, 32'h0,        10, 32'hCAFEF00D));
    tbl.push_back(mk(0, 1, 0, 64'h208, 32'h11111111, 0,  32'h0));
    tbl.push_back(mk(0, 1, 1, 64'h208, 32'h22222222, 0,  32'h0));
    tbl.push_back(mk(0, 0, 0, 64'h208, 32'h33333333, -1, 32'h0));
    tbl.push_back(mk(0, 0, 1, 64'h20B, 32'h0,        0,  32'h11111111));

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_req_rdy d%0d", d), 64'(req_rdy[d]), 64'd0);
      chk($sformatf("reset_ack_vld d%0d", d), 64'(ack_vld[d]), 64'd0);
      chk($sformatf("reset_rd_data d%0d", d), 64'(rd_data[d]), 64'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset d0", 64'(req_rdy[0]), 64'd1);
    chk("rdy_after_reset d1", 64'(req_rdy[1]), 64'd1);

    foreach (tbl[i]) run_vec(tbl[i]);

    // req_vld pulsed between edges must not start a write
    req_vld[0] = 1'b1; wr_en[0] = 1'b1; rd_en[0] = 1'b0; addr[0] = 64'h200; wr_data[0] = 32'h0;
    #2;
    req_vld[0] = 1'b0;
    @(negedge clk);
    chk("glitch_ack_vld", 64'(ack_vld[0]), 64'd0);
    chk("glitch_req_rdy", 64'(req_rdy[0]), 64'd1);
    run_vec(mk(0, 0, 1, 64'h200, 32'h0, 0, 32'hFFFFFFFF));

    // Reset with d0 in ACK of a read and d1 in WAIT after a write
    void'(model_op(1, 1'b1, 1'b0, 64'h210, 32'h55));
    req_vld[0] = 1'b1; wr_en[0] = 1'b0; rd_en[0] = 1'b1; addr[0] = 64'h204;
    req_vld[1] = 1'b1; wr_en[1] = 1'b1; rd_en[1] = 1'b0; addr[1] = 64'h210; wr_data[1] = 32'h55;
    @(negedge clk);
    req_vld[0] = 1'b0; req_vld[1] = 1'b0;
    chk("pre_rst_ack_vld d0", 64'(ack_vld[0]), 64'd1);
    chk("pre_rst_rd_data d0", 64'(rd_data[0]), 64'hCAFEF00D);
    chk("pre_rst_ack_vld d1", 64'(ack_vld[1]), 64'd0);
    #2 rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midrst_ack_vld d%0d", d), 64'(ack_vld[d]), 64'd0);
      chk($sformatf("midrst_req_rdy d%0d", d), 64'(req_rdy[d]), 64'd0);
      chk($sformatf("midrst_rd_data d%0d", d), 64'(rd_data[d]), 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    run_vec(mk(1, 0, 1, 64'h210, 32'h0, 0, 32'h55));
    run_vec(mk(0, 0, 1, 64'h204, 32'h0, 0, 32'hCAFEF00D));

    // Random traffic against the model, after preloading every word
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        logic [31:0] v;
        logic [31:0] e;
        v = $urandom;
        e = model_op(d, 1'b1, 1'b0, 64'h200 + 64'(i * 4), v);
        txn(d, 1'b1, 1'b0, 64'h200 + 64'(i * 4), v, -1, e);
      end
    end
    for (int k = 0; k < 200; k++) begin
      int          d;
      logic        w;
      logic        r;
      logic [63:0] a;
      logic [31:0] wd;
      logic [31:0] e;
      int          hold;
      d    = int'($urandom_range(0, 1));
      w    = 1'($urandom);
      r    = 1'($urandom);
      a    = 64'h1F0 + 64'($urandom_range(0, 32'h120));
      if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
      wd   = $urandom;
      hold = int'($urandom_range(0, 3)) - 1;
      e    = model_op(d, w, r, a, wd);
      txn(d, w, r, a, wd, hold, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_native_mem_responder.md
Name: reg_native_mem_responder

Overview:
- Responder (slave) end of the reg_native_if handshake. Decodes a byte-addressed window into a word-organised internal memory and answers one transaction at a time.
- Allows a programmable number of wait states before the acknowledge.
- Sits downstream of a regslv ext_* port as a synthesizable external memory target.
- Also serves as a reference responder for upstream initiators on the bench.

Parameters:
- ADDR_WIDTH, 64, width of addr.
- DATA_WIDTH, 32, width of wr_data/rd_data; one memory word = DATA_WIDTH/8 bytes.
- MEM_AW, 6, log2 of memory depth (64 words).
- BASE_ADDR, 64'h200, byte address of word 0.
- WAIT_CYCLES, 0, extra cycles between accept and ack_vld (0..15).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_vld  in  1  request valid from initiator
- req_rdy  out  1  responder can accept a request
- wr_en  in  1  write request, qualified by req_vld
- rd_en  in  1  read request, qualified by req_vld
- addr  in  ADDR_WIDTH  byte address
- wr_data  in  DATA_WIDTH  write data
- ack_vld  out  1  response valid
- ack_rdy  in  1  initiator accepts response
- rd_data  out  DATA_WIDTH  read data, valid while ack_vld

Behaviour:
- Reset and clocking:
  - One clock, clk.
  - Reset is asynchronous, active-low, on rstn.
  - Reset values: req_rdy=0, ack_vld=0, rd_data=0, state=IDLE, wait counter=0.
  - Memory array has no reset; contents are undefined after power-up.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: req_rdy=1. On req_vld&&req_rdy at a posedge (accept):
    - go to WAIT if WAIT_CYCLES>0, loading the counter with WAIT_CYCLES-1;
    - otherwise go to ACK.
  - WAIT: req_rdy=0. Counter decrements each cycle; at 0 go to ACK.
  - ACK: ack_vld=1, req_rdy=0. On ack_vld&&ack_rdy go to IDLE; req_rdy=1 in the following cycle.
  - Holding ack_rdy high early is legal.
- Latency: ack_vld rises WAIT_CYCLES+1 cycles after the accepting edge. Minimum transaction is 3 cycles: accept, ack, req_rdy again.
- Decode:
  - offset = addr - BASE_ADDR, computed at ADDR_WIDTH.
  - Hit when addr >= BASE_ADDR and offset < DEPTH*(DATA_WIDTH/8).
  - Word index = offset >> log2(DATA_WIDTH/8).
  - Low byte-offset bits are ignored.
- Write (wr_en=1, rd_en=0):
  - The memory word is updated at the accepting edge.
  - rd_data=0 during ACK.
  - A miss is dropped silently and still acknowledged.
- Read (rd_en=1, wr_en=0):
  - The word is captured into the rd_data register at the accepting edge.
  - rd_data is held stable for the whole ACK state.
  - A miss returns 0.
- Illegal request (wr_en==rd_en at accept): no memory effect, rd_data=0, acknowledged normally so the initiator never hangs.
- Inputs are sampled only at accept. Changes to addr, wr_data, wr_en or rd_en after accept have no effect.
- req_vld dropped while in IDLE before accept: nothing happens.
- Exactly one outstanding transaction; no new request is accepted while in WAIT or ACK.
- rd_data returns to 0 when leaving ACK.
- Reset asserted mid-transaction:
  - the transaction is abandoned and outputs return to reset values immediately;
  - a write that has already occurred at the accept edge persists.
- Back-pressure: ACK is held indefinitely while ack_rdy=0; rd_data does not change.

Decomposition:
- Package reg_native_pkg holds:
  - state enum {IDLE, WAIT, ACK};
  - default ADDR_WIDTH/DATA_WIDTH constants;
  - function for bytes-per-word and its log2.
- Sub-module reg_native_sram: single-port synchronous array, DATA_WIDTH x 2^MEM_AW, with we, widx, wdata, and a registered rdata on the same edge.
- Decode, FSM and wait counter stay in the top module.

Test Plan:
- Write 0xFFFFFFFF to 0x200, then read 0x200 with WAIT_CYCLES=0:
  - ack_vld exactly 1 cycle after each accept;
  - write-ack rd_data=0;
  - read-ack rd_data=0xFFFFFFFF.
- WAIT_CYCLES=3: write 0xA5A5A5A5 to 0x2FC, then read 0x2FC:
  - ack_vld rises 4 cycles after accept;
  - read returns 0xA5A5A5A5 (last word, boundary hit).
- Out of range:
  - write 0x12345678 to 0x300 and to 0x1FC, both acked, memory unchanged;
  - read 0x300 returns 0.
- Back-pressure: hold ack_rdy=0 for 10 cycles during a read of 0x204 (preloaded 0xCAFEF00D):
  - ack_vld stays 1 and rd_data stays 0xCAFEF00D;
  - req_rdy stays 0;
  - req_rdy=1 the cycle after ack_rdy=1.
- Illegal request wr_en=rd_en=1 to 0x208 (preloaded 0x11111111): acked with rd_data=0; a subsequent read returns 0x11111111.
- Reset mid-op: rstn=0 while in WAIT after a write of 0x55 to 0x210:
  - ack_vld, req_rdy and rd_data go to 0 immediately;
  - after release, a read of 0x210 returns 0x55.
